// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: FSM state encoding and the RV32I funct3 width codes used by
// load_store_unit and lsu_align.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StResp = 2'd3
    } lsu_state_e;

    // RV32I load/store width codes (funct3).
    localparam logic [2:0] F3_B  = 3'b000;  // lb / sb
    localparam logic [2:0] F3_H  = 3'b001;  // lh / sh
    localparam logic [2:0] F3_W  = 3'b010;  // lw / sw
    localparam logic [2:0] F3_BU = 3'b100;  // lbu
    localparam logic [2:0] F3_HU = 3'b101;  // lhu

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Ports:
//   funct3_i     width code of the transaction
//   byte_off_i   byte address bits [1:0]
//   word_i       32-bit memory word read for the transaction
//   wdata_i      right-aligned store data
//   load_data_o  addressed lane, sign- or zero-extended according to funct3_i
//   store_word_o word_i with the addressed byte/halfword replaced (sb/sh), or wdata_i (sw)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel     = word_i[{byte_off_i, 3'b000} +: 8];
        // Halfword lane is chosen by bit 1 only; bit 0 is checked for alignment upstream.
        half_sel     = word_i[{byte_off_i[1], 4'b0000} +: 16];
        load_data_o  = 32'h0;
        store_word_o = word_i;

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data_o = word_i;
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = 32'h0;
        endcase

        case (funct3_i)
            F3_B:    store_word_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H:    store_word_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            F3_W:    store_word_o = wdata_i;
            default: store_word_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit in front of a word-wide memory
// with combinational read data.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_we, req_funct3         store flag and width code
//   req_addr, req_wdata        byte address and right-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data (0 for stores/errors), error flag
//   mem_we, mem_a, mem_wd      memory write enable, word-aligned address, write data
//   mem_rd                     memory read data for mem_a, same cycle
// Flow: IDLE -> RD -> RESP (load), IDLE -> RD -> WR -> RESP (sb/sh, read-modify-write),
// IDLE -> WR -> RESP (sw), IDLE -> RESP (error, no memory access).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_err;
    logic        funct_ok;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] load_data;
    logic [31:0] store_word;

    lsu_align u_align (
        .funct3_i    (funct3_q),
        .byte_off_i  (addr_q[1:0]),
        .word_i      (word_q),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .store_word_o(store_word)
    );

    assign accept = req_valid && req_ready;

    // Request legality, evaluated on the incoming (not yet latched) request.
    always_comb begin
        if (req_we) begin
            funct_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        end else begin
            funct_ok = (req_funct3 == F3_B)  || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                       (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
        end
        case (req_funct3)
            F3_H, F3_HU: misaligned = req_addr[0];
            F3_W:        misaligned = (req_addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
        req_err      = !funct_ok || misaligned || out_of_range;
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d = StWr;
                    end else begin
                        // Loads, and sb/sh which need the old word for merging.
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                word_d  = mem_rd;
                state_d = we_q ? StWr : StResp;
            end
            StWr:   state_d = StResp;
            StResp: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end

    // Reset forces StIdle asynchronously, so every state-decoded output is
    // already quiet while reset is held; req_ready also needs the explicit gate.
    always_comb begin
        req_ready  = (state_q == StIdle) && !reset;
        resp_valid = (state_q == StResp);
        resp_err   = (state_q == StResp) && err_q;
        resp_rdata = ((state_q == StResp) && !we_q && !err_q) ? load_data : 32'h0;
        mem_we     = (state_q == StWr);
        mem_a      = ((state_q == StRd) || (state_q == StWr)) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wd     = (state_q == StWr) ? store_word : 32'h0;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 65536, meaning number of 32-bit words in the attached data memory.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width code: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data.
REQ-013 SHALL have port resp_err  output  1  misaligned, illegal funct3 or out-of-range address.
REQ-014 SHALL have port mem_we  output  1  memory write enable.
REQ-015 SHALL have port mem_a  output  32  word-aligned memory byte address (bits [1:0] = 00).
REQ-016 SHALL have port mem_wd  output  32  memory write data.
REQ-017 SHALL have port mem_rd  input  32  memory read data (combinational, same-cycle).

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, RESP.
REQ-019 SHALL assert req_ready only in IDLE with reset low; a request is accepted on a clk edge with req_valid && req_ready, latching we, funct3, addr and wdata.
REQ-020 SHALL, on accept, go to RESP with resp_err=1 and no memory access if the request is misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=00), has an illegal funct3, or has addr[31:2] >= MEM_WORDS.
REQ-021 SHALL route a valid load or sb/sh to RD; SHALL route sw to WR.
REQ-022 SHALL, in RD, drive mem_a={addr[31:2],2'b00} and capture mem_rd at the clk edge; a load then goes to RESP, sb/sh to WR.
REQ-023 SHALL, in WR, assert mem_we for exactly one cycle with mem_wd = wdata (sw) or the captured word with only the addressed byte/halfword lanes replaced (sb/sh); then go to RESP.
REQ-024 SHALL, in RESP, pulse resp_valid for one cycle, then return to IDLE; there is no response backpressure.
REQ-025 SHALL present resp_rdata as the selected lane, sign-extended for lb/lh and zero-extended for lbu/lhu, for loads only; resp_rdata SHALL be 0 for stores and errors.
REQ-026 SHALL give accept-to-resp_valid latencies of: load 2 cycles, sw 2, sb/sh 3, error 1.
REQ-027 SHALL drive mem_we=0 in every state other than WR, and SHALL drive mem_a=0 and mem_wd=0 in IDLE and RESP.
REQ-028 SHALL accept at most one outstanding request; the next request is accepted no earlier than the cycle after resp_valid.

Reset
REQ-029 SHALL asynchronously force state IDLE with all registered fields cleared when reset is asserted.
REQ-030 SHALL hold req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0 and mem_wd=0 while reset is asserted.
REQ-031 SHALL, on reset asserted mid-transaction (including WR), drop the transaction with no memory write after reset assertion and no resp_valid.

Structure
REQ-032 SHALL place the FSM state enum and the funct3 width constants in shared package lsu_pkg.
REQ-033 SHALL implement byte-lane extraction/extension and store merging in a combinational sub-module lsu_align.

Verification
REQ-034 SHALL verify: memory word 0x2000 = 0x0000000A; lw 0x2000 -> resp_valid 2 cycles after accept, resp_rdata 0x0000000A, resp_err 0.
REQ-035 SHALL verify: sb 0x2001 with wdata 0x000000FF on word 0x0000000A -> mem_we high for exactly one cycle, word becomes 0x0000FF0A, resp after 3 cycles.
REQ-036 SHALL verify: after that store, lb 0x2001 -> 0xFFFFFFFF; lbu 0x2001 -> 0x000000FF; lhu 0x2000 -> 0x0000FF0A.
REQ-037 SHALL verify: lw 0x2002 and sh 0x2003 -> resp_err 1 one cycle after accept, mem_we never asserted, resp_rdata 0.
REQ-038 SHALL verify: reset asserted during WR of sh 0x2000 with wdata 0x1234 -> mem_we falls immediately, memory unchanged, no resp_valid, req_ready=1 the cycle after release.
REQ-039 SHALL verify: req_valid held high for two sw requests -> second accepted in the cycle after the first resp_valid, and both words written in order.
